// File: rtl/ir_beacon_tx.sv
// rtl/ir_beacon_tx.sv - F/C frequency-coded IR beacon transmitter (IDLE/MARK/SPACE bursts)
// Optional feature macro: CARRIER_EN (gates the tone with a ~38 kHz carrier).
module ir_beacon_tx #(
  parameter int F_HALF       = 100000,
  parameter int C_HALF       = 25000,
  parameter int MARK_CYC     = 10000000,
  parameter int SPACE_CYC    = 5000000,
  parameter int CARRIER_HALF = 1316
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic [1:0] code,
  input  logic [3:0] bursts,
  output logic       ir_out,
  output logic       busy,
  output logic       burst_done
);

  localparam int MAX_1 = (F_HALF > C_HALF) ? F_HALF : C_HALF;
  localparam int MAX_2 = (MARK_CYC > SPACE_CYC) ? MARK_CYC : SPACE_CYC;
  localparam int MAX_3 = (MAX_1 > MAX_2) ? MAX_1 : MAX_2;
  localparam int MAXP  = (MAX_3 > CARRIER_HALF) ? MAX_3 : CARRIER_HALF;
  localparam int CW    = $clog2(MAXP + 1);

  localparam logic [CW-1:0] F_LAST     = CW'(F_HALF - 1);
  localparam logic [CW-1:0] C_LAST     = CW'(C_HALF - 1);
  localparam logic [CW-1:0] MARK_LAST  = CW'(MARK_CYC - 1);
  localparam logic [CW-1:0] SPACE_LAST = CW'(SPACE_CYC - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] half_cnt, half_n, cyc_cnt, cyc_n, half_last;
  logic [3:0]    rem, rem_n;
  logic          sel_c, sel_c_n, cont, cont_n, tone, tone_n;
  logic          ready_n, busy_n, done_n, ir_n;
  logic          accept, tone_code, go_mark;
`ifdef CARRIER_EN
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);
  logic [CW-1:0] car_cnt, car_cnt_n;
  logic          car, car_n;
`endif

  assign half_last = sel_c ? C_LAST : F_LAST;

  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    cyc_n     = cyc_cnt;
    rem_n     = rem;
    sel_c_n   = sel_c;
    cont_n    = cont;
    tone_n    = tone;
    done_n    = 1'b0;
    go_mark   = 1'b0;
    accept    = code_valid && code_ready;
    tone_code = (code == 2'b01) || (code == 2'b10);
`ifdef CARRIER_EN
    car_n     = car;
    car_cnt_n = car_cnt;
`endif
    if (accept) begin
      sel_c_n = (code == 2'b10);
      cont_n  = (bursts == 4'd0);
      rem_n   = bursts;
    end
    case (state)
      IDLE: if (accept && tone_code) go_mark = 1'b1;
      MARK: begin
        if (accept) begin
          // Only reachable in continuous mode: a tone code restarts, an off code aborts.
          if (tone_code) go_mark = 1'b1;
          else begin
            state_n = IDLE;
            tone_n  = 1'b0;
          end
        end else begin
          if (half_cnt == half_last) begin
            half_n = '0;
            tone_n = ~tone;
          end else half_n = half_cnt + 1'b1;
`ifdef CARRIER_EN
          if (car_cnt == CAR_LAST) begin
            car_cnt_n = '0;
            car_n     = ~car;
          end else car_cnt_n = car_cnt + 1'b1;
`endif
          if (!cont) begin
            if (cyc_cnt == MARK_LAST) begin
              state_n = SPACE;
              cyc_n   = '0;
              tone_n  = 1'b0;
            end else cyc_n = cyc_cnt + 1'b1;
          end
        end
      end
      SPACE: begin
        if (cyc_cnt == SPACE_LAST) begin
          rem_n = rem - 4'd1;
          cyc_n = '0;
          if (rem != 4'd1) go_mark = 1'b1;
          else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else cyc_n = cyc_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (go_mark) begin
      state_n = MARK;
      half_n  = '0;
      cyc_n   = '0;
      tone_n  = 1'b1;
`ifdef CARRIER_EN
      car_n     = 1'b1;
      car_cnt_n = '0;
`endif
    end
    ready_n = (state_n == IDLE) || ((state_n == MARK) && cont_n);
    busy_n  = (state_n != IDLE);
`ifdef CARRIER_EN
    ir_n = tone_n & car_n;
`else
    ir_n = tone_n;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      cyc_cnt    <= '0;
      rem        <= '0;
      sel_c      <= 1'b0;
      cont       <= 1'b0;
      tone       <= 1'b0;
      code_ready <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      ir_out     <= 1'b0;
`ifdef CARRIER_EN
      car        <= 1'b0;
      car_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      half_cnt   <= half_n;
      cyc_cnt    <= cyc_n;
      rem        <= rem_n;
      sel_c      <= sel_c_n;
      cont       <= cont_n;
      tone       <= tone_n;
      code_ready <= ready_n;
      busy       <= busy_n;
      burst_done <= done_n;
      ir_out     <= ir_n;
`ifdef CARRIER_EN
      car        <= car_n;
      car_cnt    <= car_cnt_n;
`endif
    end
  end

endmodule
